// File: rtl/ugpe_pkg.sv
// Shared widths, field positions and defaults for the ungapped-extension dispatcher.
package ugpe_pkg;

  localparam int HIT_W         = 128;
  localparam int RES_W         = 32;
  localparam int DEF_NUM_ENG   = 4;
  localparam int DEF_ORD_DEPTH = 8;

  // Hit packet {seq_len, hit_pos, d_start, q_start, database, query}
  localparam int HIT_QUERY_LSB  = 0;
  localparam int HIT_QUERY_W    = 32;
  localparam int HIT_DB_LSB     = 32;
  localparam int HIT_DB_W       = 32;
  localparam int HIT_QSTART_LSB = 64;
  localparam int HIT_DSTART_LSB = 80;
  localparam int HIT_POS_LSB    = 96;
  localparam int HIT_SEQLEN_LSB = 112;
  localparam int HIT_FIELD16_W  = 16;

  // Result {d_start, q_start, len, score}, 8 bits each
  localparam int RES_FIELD_W    = 8;
  localparam int RES_SCORE_LSB  = 0;
  localparam int RES_LEN_LSB    = 8;
  localparam int RES_QSTART_LSB = 16;
  localparam int RES_DSTART_LSB = 24;

  function automatic logic [RES_FIELD_W-1:0] res_score(input logic [RES_W-1:0] res);
    return res[RES_SCORE_LSB +: RES_FIELD_W];
  endfunction

endpackage

// File: rtl/ugpe_dispatcher_if.sv
// Hit input, per-engine request/response and in-order result stream of the dispatcher.
interface ugpe_dispatcher_if
  import ugpe_pkg::*;
#(
  parameter int NUM_ENG = DEF_NUM_ENG
);

  logic                     istream_val;
  logic                     istream_rdy;
  logic [HIT_W-1:0]         istream_msg;

  logic [NUM_ENG-1:0]       eng_req_val;
  logic [NUM_ENG-1:0]       eng_req_rdy;
  logic [HIT_W-1:0]         eng_req_msg;

  logic [NUM_ENG-1:0]       eng_resp_val;
  logic [NUM_ENG-1:0]       eng_resp_rdy;
  logic [RES_W*NUM_ENG-1:0] eng_resp_msg;

  logic                     ostream_val;
  logic                     ostream_rdy;
  logic [RES_W-1:0]         ostream_msg;

  // Dispatcher side
  modport slave (
    input  istream_val, istream_msg, eng_req_rdy, eng_resp_val, eng_resp_msg, ostream_rdy,
    output istream_rdy, eng_req_val, eng_req_msg, eng_resp_rdy, ostream_val, ostream_msg
  );

  // Hit source, engines and result sink
  modport master (
    output istream_val, istream_msg, eng_req_rdy, eng_resp_val, eng_resp_msg, ostream_rdy,
    input  istream_rdy, eng_req_val, eng_req_msg, eng_resp_rdy, ostream_val, ostream_msg
  );

endinterface

// File: rtl/ugpe_order_fifo.sv
// Order queue: FIFO of engine indices recording dispatch order.
module ugpe_order_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ugpe_dispatcher.sv
// Round-robin hit dispatcher with in-order result return across NUM_ENG engines.
// Optional build macro UGPE_DISPATCH_DROP_ZERO_EN: silently consume zero-score head results.
module ugpe_dispatcher
  import ugpe_pkg::*;
#(
  parameter int NUM_ENG   = DEF_NUM_ENG,
  parameter int ORD_DEPTH = DEF_ORD_DEPTH
) (
  input logic              clk,
  input logic              reset,
  ugpe_dispatcher_if.slave io
);

  localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_found;
  logic [IDX_W:0]         cand_w;
  logic [IDX_W-1:0]       cand;
  logic                   dispatch;

  logic [IDX_W-1:0]       head_idx;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(ORD_DEPTH):0] occ;
  logic                   head_val;
  logic                   head_rv;
  logic [RES_W-1:0]       head_msg;
  logic                   drop_zero;
  logic                   resp_take;
  logic                   pop;

  // First ready engine at or after rr_ptr, wrapping at NUM_ENG
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_w      = '0;
    cand        = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      cand_w = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand_w >= (IDX_W+1)'(NUM_ENG)) cand_w = cand_w - (IDX_W+1)'(NUM_ENG);
      cand = cand_w[IDX_W-1:0];
      if (!grant_found && io.eng_req_rdy[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Registered fullness only: a same-cycle pop never opens room for a push
  assign io.istream_rdy = !reset && grant_found && !fifo_full;
  assign dispatch       = io.istream_val && io.istream_rdy;
  assign io.eng_req_val = dispatch ? (NUM_ENG'(1) << grant_idx) : '0;
  assign io.eng_req_msg = io.istream_msg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (dispatch) begin
      rr_ptr <= (grant_idx == IDX_W'(NUM_ENG-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  ugpe_order_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (ORD_DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (dispatch),
    .push_data (grant_idx),
    .pop       (pop),
    .pop_data  (head_idx),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ)
  );

  assign head_val = !reset && !fifo_empty;

  always_comb begin
    head_msg = '0;
    head_rv  = 1'b0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (head_idx == IDX_W'(k)) begin
        head_msg = io.eng_resp_msg[k*RES_W +: RES_W];
        head_rv  = io.eng_resp_val[k];
      end
    end
  end

`ifdef UGPE_DISPATCH_DROP_ZERO_EN
  assign drop_zero = head_val && head_rv && (res_score(head_msg) == '0);
`else
  assign drop_zero = 1'b0;
`endif

  // Only the head engine is ever offered ready; all others hold their result
  assign resp_take       = head_val && (drop_zero || io.ostream_rdy);
  assign pop             = resp_take && head_rv;
  assign io.eng_resp_rdy = resp_take ? (NUM_ENG'(1) << head_idx) : '0;
  assign io.ostream_val  = head_val && head_rv && !drop_zero;
  assign io.ostream_msg  = head_msg;

  occ_in_range: assert property (@(posedge clk) disable iff (reset)
    occ <= ($clog2(ORD_DEPTH)+1)'(ORD_DEPTH));

endmodule

// File: tb/tb_ugpe_dispatcher.sv
// Directed self-checking bench for ugpe_dispatcher (NUM_ENG=4, ORD_DEPTH=4).
module tb_ugpe_dispatcher;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  ugpe_dispatcher_if #(.NUM_ENG(4)) io ();

  ugpe_dispatcher #(.NUM_ENG(4), .ORD_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] RES0 = 32'hD0C0_1001;
  localparam logic [31:0] RES1 = 32'hD1C1_1102;
  localparam logic [31:0] RES2 = 32'hD2C2_1203;
  localparam logic [31:0] RES3 = 32'hD3C3_1304;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_res(input int i, input logic [31:0] v);
    io.eng_resp_msg[i*32 +: 32] = v;
  endtask

  task automatic clear_inputs();
    io.istream_val  = 1'b0;
    io.istream_msg  = '0;
    io.eng_req_rdy  = '0;
    io.eng_resp_val = '0;
    io.eng_resp_msg = '0;
    io.ostream_rdy  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    cyc();
    reset = 1'b0;
  endtask

  task automatic load_results();
    set_res(0, RES0); set_res(1, RES1); set_res(2, RES2); set_res(3, RES3);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    io.eng_req_rdy = 4'hF; io.eng_resp_val = 4'hF; io.istream_val = 1'b1; io.ostream_rdy = 1'b1;
    cyc(); settle();
    chk_cnt++; if (io.istream_rdy !== 1'b0) $display("FAIL rst_istream_rdy: got %b need 0", io.istream_rdy); else pass_cnt++;
    chk_cnt++; if (io.eng_req_val !== 4'b0000) $display("FAIL rst_eng_req_val: got %b need 0000", io.eng_req_val); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0000) $display("FAIL rst_eng_resp_rdy: got %b need 0000", io.eng_resp_rdy); else pass_cnt++;
    chk_cnt++; if (io.ostream_val !== 1'b0) $display("FAIL rst_ostream_val: got %b need 0", io.ostream_val); else pass_cnt++;
    reset = 1'b0;
    io.istream_val = 1'b0;
    settle();
    chk_cnt++; if (io.istream_rdy !== 1'b1) $display("FAIL idle_istream_rdy: got %b need 1", io.istream_rdy); else pass_cnt++;
    chk_cnt++; if (io.ostream_val !== 1'b0) $display("FAIL empty_ostream_val: got %b need 0", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0000) $display("FAIL empty_eng_resp_rdy: got %b need 0000", io.eng_resp_rdy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]   exp_g;
    logic [127:0] hit;
    logic [31:0]  exp_r [4];
    exp_r[0] = RES0; exp_r[1] = RES1; exp_r[2] = RES2; exp_r[3] = RES3;
    do_reset();
    io.eng_req_rdy = 4'hF;
    io.istream_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hit = {16'd40, 16'(i + 7), 16'h0003, 16'h0004, 32'hDB00_0001, 32'(i + 32'h0A0A)};
      io.istream_msg = hit;
      exp_g = 4'b0001 << i;
      settle();
      chk_cnt++; if (io.eng_req_val !== exp_g) $display("FAIL b2b_grant%0d: got %b need %b", i, io.eng_req_val, exp_g); else pass_cnt++;
      chk_cnt++; if (io.eng_req_msg !== hit) $display("FAIL b2b_msg%0d: got %h need %h", i, io.eng_req_msg, hit); else pass_cnt++;
      cyc();
    end
    io.istream_val = 1'b0;
    load_results();
    io.eng_resp_val = 4'hF;
    io.ostream_rdy  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_g = 4'b0001 << j;
      settle();
      chk_cnt++; if (io.ostream_msg !== exp_r[j]) $display("FAIL b2b_out%0d: got %h need %h", j, io.ostream_msg, exp_r[j]); else pass_cnt++;
      chk_cnt++; if (io.eng_resp_rdy !== exp_g) $display("FAIL b2b_resp_rdy%0d: got %b need %b", j, io.eng_resp_rdy, exp_g); else pass_cnt++;
      cyc();
    end
    io.ostream_rdy  = 1'b0;
    io.eng_resp_val = 4'h0;
    io.istream_val  = 1'b1;
    settle();
    chk_cnt++; if (io.eng_req_val !== 4'b0001) $display("FAIL b2b_rr_wrap: got %b need 0001", io.eng_req_val); else pass_cnt++;
  endtask

  task automatic test_rr_skip_busy();
    do_reset();
    io.istream_val = 1'b1;
    io.eng_req_rdy = 4'b0001;
    settle();
    chk_cnt++; if (io.eng_req_val !== 4'b0001) $display("FAIL rr_first: got %b need 0001", io.eng_req_val); else pass_cnt++;
    cyc();
    io.eng_req_rdy = 4'b1101;
    settle();
    chk_cnt++; if (io.eng_req_val !== 4'b0100) $display("FAIL rr_skip_busy: got %b need 0100", io.eng_req_val); else pass_cnt++;
    cyc();
    io.eng_req_rdy = 4'hF;
    settle();
    chk_cnt++; if (io.eng_req_val !== 4'b1000) $display("FAIL rr_after_skip: got %b need 1000", io.eng_req_val); else pass_cnt++;
    cyc();
    settle();
    chk_cnt++; if (io.eng_req_val !== 4'b0001) $display("FAIL rr_wrap: got %b need 0001", io.eng_req_val); else pass_cnt++;
    cyc();
    settle();
    chk_cnt++; if (io.istream_rdy !== 1'b0) $display("FAIL rr_full_rdy: got %b need 0", io.istream_rdy); else pass_cnt++;
    io.istream_val  = 1'b0;
    load_results();
    io.eng_resp_val = 4'hF;
    io.ostream_rdy  = 1'b1;
    settle();
    chk_cnt++; if (io.ostream_msg !== RES0) $display("FAIL rr_order0: got %h need %h", io.ostream_msg, RES0); else pass_cnt++;
    cyc(); settle();
    chk_cnt++; if (io.ostream_msg !== RES2) $display("FAIL rr_order1: got %h need %h", io.ostream_msg, RES2); else pass_cnt++;
    cyc(); settle();
    chk_cnt++; if (io.ostream_msg !== RES3) $display("FAIL rr_order2: got %h need %h", io.ostream_msg, RES3); else pass_cnt++;
  endtask

  task automatic test_in_order();
    logic [31:0] res_a;
    logic [31:0] res_b;
    res_a = 32'h1122_3344;
    res_b = 32'h5566_7788;
    do_reset();
    io.eng_req_rdy = 4'hF;
    io.istream_val = 1'b1;
    io.istream_msg = 128'hA;
    cyc();
    io.istream_msg = 128'hB;
    cyc();
    io.istream_val  = 1'b0;
    io.eng_req_rdy  = 4'h0;
    io.ostream_rdy  = 1'b1;
    set_res(1, res_b);
    io.eng_resp_val = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_cnt++; if (io.ostream_val !== 1'b0) $display("FAIL ord_wait_val%0d: got %b need 0", i, io.ostream_val); else pass_cnt++;
      chk_cnt++; if (io.eng_resp_rdy !== 4'b0001) $display("FAIL ord_wait_rdy%0d: got %b need 0001", i, io.eng_resp_rdy); else pass_cnt++;
      cyc();
    end
    set_res(0, res_a);
    io.eng_resp_val = 4'b0011;
    settle();
    chk_cnt++; if (io.ostream_val !== 1'b1) $display("FAIL ord_a_val: got %b need 1", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.ostream_msg !== res_a) $display("FAIL ord_a_msg: got %h need %h", io.ostream_msg, res_a); else pass_cnt++;
    cyc();
    io.eng_resp_val = 4'b0010;
    settle();
    chk_cnt++; if (io.ostream_msg !== res_b) $display("FAIL ord_b_msg: got %h need %h", io.ostream_msg, res_b); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0010) $display("FAIL ord_b_rdy: got %b need 0010", io.eng_resp_rdy); else pass_cnt++;
    cyc();
    io.eng_resp_val = 4'b0000;
    settle();
    chk_cnt++; if (io.ostream_val !== 1'b0) $display("FAIL ord_drained_val: got %b need 0", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0000) $display("FAIL ord_drained_rdy: got %b need 0000", io.eng_resp_rdy); else pass_cnt++;
  endtask

  task automatic test_full();
    int acc;
    acc = 0;
    do_reset();
    load_results();
    io.eng_req_rdy  = 4'hF;
    io.eng_resp_val = 4'hF;
    io.istream_val  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      if (io.istream_rdy === 1'b1) acc++;
      cyc();
    end
    chk_cnt++; if (acc !== 4) $display("FAIL full_accepts: got %0d need 4", acc); else pass_cnt++;
    settle();
    chk_cnt++; if (io.istream_rdy !== 1'b0) $display("FAIL full_rdy_low: got %b need 0", io.istream_rdy); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0000) $display("FAIL full_backpressure: got %b need 0000", io.eng_resp_rdy); else pass_cnt++;
    io.ostream_rdy = 1'b1;
    settle();
    chk_cnt++; if (io.istream_rdy !== 1'b0) $display("FAIL full_pop_no_push: got %b need 0", io.istream_rdy); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0001) $display("FAIL full_pop_rdy: got %b need 0001", io.eng_resp_rdy); else pass_cnt++;
    cyc();
    io.ostream_rdy = 1'b0;
    settle();
    chk_cnt++; if (io.istream_rdy !== 1'b1) $display("FAIL full_reopen: got %b need 1", io.istream_rdy); else pass_cnt++;
    chk_cnt++; if (io.eng_req_val !== 4'b0001) $display("FAIL full_reopen_grant: got %b need 0001", io.eng_req_val); else pass_cnt++;
    cyc();
    settle();
    chk_cnt++; if (io.istream_rdy !== 1'b0) $display("FAIL full_again: got %b need 0", io.istream_rdy); else pass_cnt++;
    io.ostream_rdy = 1'b1;
    cyc();
    settle();
    chk_cnt++; if (io.eng_req_val !== 4'b0010) $display("FAIL pp_grant: got %b need 0010", io.eng_req_val); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0100) $display("FAIL pp_head: got %b need 0100", io.eng_resp_rdy); else pass_cnt++;
    cyc();
    settle();
    chk_cnt++; if (io.istream_rdy !== 1'b1) $display("FAIL pp_occ_kept: got %b need 1", io.istream_rdy); else pass_cnt++;
    chk_cnt++; if (io.ostream_msg !== RES3) $display("FAIL pp_next_head: got %h need %h", io.ostream_msg, RES3); else pass_cnt++;
    io.istream_val = 1'b0;
  endtask

  task automatic test_drop_zero();
    do_reset();
    io.eng_req_rdy = 4'hF;
    io.istream_val = 1'b1;
    cyc();
    cyc();
    io.istream_val  = 1'b0;
    io.eng_req_rdy  = 4'h0;
    set_res(0, 32'h0A0B_0300);
    set_res(1, 32'h0A0B_0305);
    io.eng_resp_val = 4'b0011;
    settle();
`ifdef UGPE_DISPATCH_DROP_ZERO_EN
    chk_cnt++; if (io.ostream_val !== 1'b0) $display("FAIL drop_val: got %b need 0", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0001) $display("FAIL drop_rdy: got %b need 0001", io.eng_resp_rdy); else pass_cnt++;
    cyc();
    io.eng_resp_val = 4'b0010;
    settle();
    chk_cnt++; if (io.ostream_val !== 1'b1) $display("FAIL keep_val: got %b need 1", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.ostream_msg !== 32'h0A0B_0305) $display("FAIL keep_msg: got %h need 0a0b0305", io.ostream_msg); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0000) $display("FAIL keep_hold: got %b need 0000", io.eng_resp_rdy); else pass_cnt++;
    io.ostream_rdy = 1'b1;
    settle();
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0010) $display("FAIL keep_rdy: got %b need 0010", io.eng_resp_rdy); else pass_cnt++;
`else
    chk_cnt++; if (io.ostream_val !== 1'b1) $display("FAIL zero_fwd_val: got %b need 1", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.ostream_msg !== 32'h0A0B_0300) $display("FAIL zero_fwd_msg: got %h need 0a0b0300", io.ostream_msg); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0000) $display("FAIL zero_fwd_hold: got %b need 0000", io.eng_resp_rdy); else pass_cnt++;
    io.ostream_rdy = 1'b1;
    settle();
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0001) $display("FAIL zero_fwd_rdy: got %b need 0001", io.eng_resp_rdy); else pass_cnt++;
    cyc();
    io.eng_resp_val = 4'b0010;
    settle();
    chk_cnt++; if (io.ostream_val !== 1'b1) $display("FAIL nz_val: got %b need 1", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.ostream_msg !== 32'h0A0B_0305) $display("FAIL nz_msg: got %h need 0a0b0305", io.ostream_msg); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    io.eng_req_rdy = 4'hF;
    io.istream_val = 1'b1;
    cyc(); cyc(); cyc();
    io.istream_val  = 1'b0;
    load_results();
    io.eng_resp_val = 4'hF;
    reset = 1'b1;
    settle();
    chk_cnt++; if (io.ostream_val !== 1'b0) $display("FAIL mid_rst_val: got %b need 0", io.ostream_val); else pass_cnt++;
    cyc();
    reset = 1'b0;
    io.ostream_rdy = 1'b1;
    settle();
    chk_cnt++; if (io.ostream_val !== 1'b0) $display("FAIL mid_after_val: got %b need 0", io.ostream_val); else pass_cnt++;
    chk_cnt++; if (io.eng_resp_rdy !== 4'b0000) $display("FAIL mid_after_empty: got %b need 0000", io.eng_resp_rdy); else pass_cnt++;
    io.istream_val = 1'b1;
    settle();
    chk_cnt++; if (io.eng_req_val !== 4'b0001) $display("FAIL mid_after_rr: got %b need 0001", io.eng_req_val); else pass_cnt++;
    io.istream_val = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_rr_skip_busy();
    test_in_order();
    test_full();
    test_drop_zero();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ugpe_dispatcher.md
UGPE_DISPATCHER -- requirements
Module: ugpe_dispatcher

Interface
REQ-001 Parameter NUM_ENG, default 4: number of attached ungapped-extension engines (2..8).
REQ-002 Parameter ORD_DEPTH, default 8: order-queue entries (power of 2, at least NUM_ENG).
REQ-003 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port istream_val, input, 1: hit request valid.
REQ-006 Port istream_rdy, output, 1: dispatcher accepts a hit this cycle.
REQ-007 Port istream_msg, input, 128: hit packet {seq_len, hit_pos, d_start, q_start, database, query}.
REQ-008 Port eng_req_val, output, NUM_ENG: per-engine request valid, one-hot or zero.
REQ-009 Port eng_req_rdy, input, NUM_ENG: per-engine idle/ready.
REQ-010 Port eng_req_msg, output, 128: broadcast copy of istream_msg.
REQ-011 Port eng_resp_val, input, NUM_ENG: per-engine result valid.
REQ-012 Port eng_resp_rdy, output, NUM_ENG: per-engine result accept, one-hot or zero.
REQ-013 Port eng_resp_msg, input, 32*NUM_ENG: engine i result in bits [32i+31:32i], format {d_start, q_start, len, score} in 8-bit fields.
REQ-014 Port ostream_val, output, 1: in-order result valid.
REQ-015 Port ostream_rdy, input, 1: downstream accepts result.
REQ-016 Port ostream_msg, output, 32: result of the oldest outstanding hit.

Function
REQ-017 Dispatch grant goes to the first engine with eng_req_rdy high, searching round-robin from rr_ptr.
REQ-018 istream_rdy is high when any eng_req_rdy bit is high and the order queue is not full.
REQ-019 eng_req_val[g] equals istream_val AND istream_rdy for granted engine g only; the handshake completes in the same cycle (zero latency).
REQ-020 On a dispatch, rr_ptr becomes (g+1) mod NUM_ENG and g is pushed into the order queue; otherwise rr_ptr holds.
REQ-021 The order queue is a FIFO of engine indices; head h names the engine owing the next output.
REQ-022 ostream_val equals (queue not empty) AND eng_resp_val[h]; ostream_msg equals the slice of engine h.
REQ-023 eng_resp_rdy[h] equals ostream_rdy AND queue not empty; all other eng_resp_rdy bits are 0.
REQ-024 Results from non-head engines are held at the engine (back-pressure); none are buffered in the dispatcher.
REQ-025 On a completed output handshake, the queue pops.
REQ-026 Push and pop in the same cycle are both allowed; occupancy is unchanged. When full, a same-cycle pop does not enable a push; fullness is evaluated from registered occupancy.
REQ-027 Occupancy counter width is clog2(ORD_DEPTH)+1; read/write pointers wrap modulo ORD_DEPTH.
REQ-028 An eng_resp_val from an engine not at head is never consumed or reordered.
REQ-029 Output busy flag: ostream_val stays low while the queue is empty, regardless of eng_resp_val.

Reset
REQ-030 Reset clears rr_ptr to 0, clears queue pointers and occupancy to 0, and drives istream_rdy, eng_req_val, eng_resp_rdy and ostream_val to 0 in the cycle after reset is sampled.
REQ-031 Reset asserted mid-operation discards all queued indices; engines are reset by the same signal.

Configuration
REQ-032 With UGPE_DISPATCH_DROP_ZERO_EN defined, a head result whose score byte equals 0 is consumed (eng_resp_rdy[h]=1 and pop) with ostream_val held low, independent of ostream_rdy.
REQ-033 Without UGPE_DISPATCH_DROP_ZERO_EN, every result is forwarded as in REQ-022 and REQ-023.

Structure
REQ-034 The shared package ugpe_pkg holds the hit/result widths (128, 32), the field bit positions, and the default NUM_ENG and ORD_DEPTH.
REQ-035 The order queue is the sub-module ugpe_order_fifo (parameterised width and depth, with full, empty and count outputs).

Verification
REQ-036 All 4 engines are ready and 4 hits are sent back-to-back -> grants go to engines 0,1,2,3 on consecutive cycles and rr_ptr returns to 0.
REQ-037 Engine 1 is busy, rr_ptr=1, and a hit arrives -> the grant goes to engine 2 and rr_ptr becomes 3.
REQ-038 Hits A→eng0 and B→eng1; eng1 responds 5 cycles before eng0 -> ostream emits A then B, and eng_resp_rdy[1] stays 0 until A is popped.
REQ-039 ORD_DEPTH=4, engines always ready, ostream_rdy=0 -> exactly 4 hits are accepted and istream_rdy falls to 0; ostream_rdy is raised -> a pop occurs and the next cycle accepts a hit.
REQ-040 With UGPE_DISPATCH_DROP_ZERO_EN, the head result is 0x0A0B0300 -> it is consumed without an ostream_val pulse; the head result 0x0A0B0305 -> it is emitted.
REQ-041 Reset is asserted with 3 hits outstanding -> the next cycle shows ostream_val=0, the queue empty, and rr_ptr=0.
